// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// uart_rx : mid-bit sampling 8N1 UART receiver with a one-entry valid/ready
//           holding register, framing and overrun pulses.
// Optional : UART_RX_PARITY_EN adds a parity bit stage and the parity_err port.
// Revision : 1.0  initial release
// ============================================================================
module uart_rx #(
   parameter int CLK_FREQ   = 50000000,
   parameter int BAUD       = 115200,
   parameter int DATA_BITS  = 8,
   parameter int PARITY_ODD = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 frame_err,
`ifdef UART_RX_PARITY_EN
   output logic                 parity_err,
`endif
   output logic                 overrun
);

   // N must be at least 4 so the half-bit start check has room to count.
   localparam int N  = CLK_FREQ / BAUD;
   localparam int H  = N / 2;
   localparam int CW = $clog2(N);
   localparam int BW = $clog2(DATA_BITS + 1);

   localparam logic [CW-1:0] CNT_HALF = CW'(H - 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(N - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_STOP   = 3'd3;
`ifdef UART_RX_PARITY_EN
   localparam logic [2:0] S_PARITY = 3'd4;
   localparam logic       ODD      = (PARITY_ODD != 0);
`endif

   logic                 sync1;
   logic                 rx_s;
   logic                 rx_prev;
   logic [2:0]           state;
   logic [CW-1:0]        cnt;
   logic [BW-1:0]        bit_cnt;
   logic [DATA_BITS-1:0] shreg;
   logic                 frame_ok;

`ifdef UART_RX_PARITY_EN
   logic parity_bit;
   logic parity_bad;
   assign parity_bad = (((^shreg) ^ ODD) != parity_bit);
   assign frame_ok   = rx_s & ~parity_bad;
`else
   logic unused_parity_odd;
   assign unused_parity_odd = (PARITY_ODD != 0);
   assign frame_ok          = rx_s;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1     <= 1'b1;
         rx_s      <= 1'b1;
         rx_prev   <= 1'b1;
         state     <= S_IDLE;
         cnt       <= '0;
         bit_cnt   <= '0;
         shreg     <= '0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_bit <= 1'b0;
         parity_err <= 1'b0;
`endif
      end else begin
         sync1     <= rx;
         rx_s      <= sync1;
         rx_prev   <= rx_s;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err <= 1'b0;
`endif
         // A delivery in the STOP branch below overrides this clear.
         if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end
         cnt <= cnt + 1'b1;

         case (state)
            S_IDLE: begin
               cnt <= '0;
               if (rx_prev && !rx_s) begin
                  state <= S_START;
               end
            end
            S_START: begin
               if (cnt == CNT_HALF) begin
                  cnt   <= '0;
                  state <= rx_s ? S_IDLE : S_DATA;
               end
            end
            S_DATA: begin
               if (cnt == CNT_FULL) begin
                  cnt   <= '0;
                  shreg <= {rx_s, shreg[DATA_BITS-1:1]};
                  if (bit_cnt == BIT_LAST) begin
                     bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
                     state   <= S_PARITY;
`else
                     state   <= S_STOP;
`endif
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
               if (cnt == CNT_FULL) begin
                  cnt        <= '0;
                  parity_bit <= rx_s;
                  state      <= S_STOP;
               end
            end
`endif
            S_STOP: begin
               if (cnt == CNT_FULL) begin
                  cnt       <= '0;
                  state     <= S_IDLE;
                  frame_err <= ~rx_s;
`ifdef UART_RX_PARITY_EN
                  parity_err <= parity_bad;
`endif
                  if (frame_ok) begin
                     if (!rx_valid || rx_ready) begin
                        rx_data  <= shreg;
                        rx_valid <= 1'b1;
                     end else begin
                        overrun <= 1'b1;
                     end
                  end
               end
            end
            default: begin
               cnt   <= '0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
